// File: rtl/moore_run_detector_pkg.sv
// Shared constants for the run detector family.
//  - RUN_DET_OVERLAP / RUN_DET_NONOVERLAP: values for the OVERLAP parameter.
//  - run_det_cw(n): width needed to hold a run length of 0..n.
package moore_run_detector_pkg;

  localparam int RUN_DET_OVERLAP    = 1;
  localparam int RUN_DET_NONOVERLAP = 0;

  // Illegal lengths still get a legal width so the elaboration error from the
  // top is the first thing reported.
  function automatic int run_det_cw(input int n);
    if (n < 1) begin
      return 1;
    end
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
// Ports:
//  clk  rising-edge clock
//  rst  asynchronous active-high reset, clears cnt
//  inc  increment request; ignored once cnt is all-ones
//  clr  synchronous clear, wins over inc
//  cnt  current count, W bits
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/moore_run_detector.sv
// Moore run detector: flags RUN_LEN consecutive sampled bits equal to
// MATCH_VAL. All outputs come from registers or from decoding registers.
// Ports:
//  clk        rising-edge clock
//  rst        asynchronous active-high reset
//  x_in       serial bit, sampled when en=1
//  en         sample enable; en=0 holds run and detection count
//  clr        synchronous clear of run_cnt, det_cnt, det_pulse (beats en)
//  y_out      high while run_cnt == RUN_LEN
//  det_pulse  one-cycle flag on entry into RUN_LEN
//  run_cnt    current run length, CW bits
//  det_cnt    saturating detection count, CNT_W bits
//
// run_cnt state | meaning
// 0             | no matching bit in progress
// 1..RUN_LEN-1  | partial run
// RUN_LEN       | run detected, y_out high
module moore_run_detector
  import moore_run_detector_pkg::*;
#(
  parameter int   RUN_LEN   = 3,
  parameter logic MATCH_VAL = 1'b0,
  parameter int   OVERLAP   = RUN_DET_OVERLAP,
  parameter int   CNT_W     = 8,
  localparam int  CW        = run_det_cw(RUN_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x_in,
  input  logic             en,
  input  logic             clr,
  output logic             y_out,
  output logic             det_pulse,
  output logic [CW-1:0]    run_cnt,
  output logic [CNT_W-1:0] det_cnt
);

  if (RUN_LEN < 1) begin : g_bad_run_len
    $error("moore_run_detector: RUN_LEN must be >= 1");
  end
  if ((OVERLAP != RUN_DET_OVERLAP) && (OVERLAP != RUN_DET_NONOVERLAP)) begin : g_bad_overlap
    $error("moore_run_detector: OVERLAP must be 0 or 1");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("moore_run_detector: CNT_W must be >= 1");
  end

  localparam logic [CW-1:0] RUN_MAX = CW'(RUN_LEN);
  localparam logic [CW-1:0] RUN_ONE = CW'(1);

  logic [CW-1:0] run_nxt;
  logic          match;
  logic          entry;

  assign match = (x_in == MATCH_VAL);

  always_comb begin
    run_nxt = run_cnt;
    entry   = 1'b0;
    if (en) begin
      if (!match) begin
        run_nxt = '0;
      end else if (run_cnt != RUN_MAX) begin
        run_nxt = run_cnt + RUN_ONE;
      end else if (OVERLAP == RUN_DET_NONOVERLAP) begin
        // The bit that would extend a finished run opens the next one.
        run_nxt = RUN_ONE;
      end else begin
        run_nxt = RUN_MAX;
      end
      // With RUN_LEN=1 the state never leaves RUN_MAX during a run, so each
      // matching bit must count as its own detection.
      entry = match && (run_nxt == RUN_MAX) &&
              ((run_cnt != RUN_MAX) || (RUN_LEN == 1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_cnt   <= '0;
      det_pulse <= 1'b0;
    end else if (clr) begin
      run_cnt   <= '0;
      det_pulse <= 1'b0;
    end else begin
      run_cnt   <= run_nxt;
      det_pulse <= entry;
    end
  end

  assign y_out = (run_cnt == RUN_MAX);

  sat_counter #(
    .W (CNT_W)
  ) u_det_cnt (
    .clk (clk),
    .rst (rst),
    .inc (entry),
    .clr (clr),
    .cnt (det_cnt)
  );

endmodule
